ibis_axil_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register file; next generation of the fixed-width, address-less Ibis AXI4 front end.
- Adds awaddr/araddr decode, configurable data width and depth, byte strobes, SLVERR on out-of-range accesses, and independent AW/W acceptance.
- Sits behind the ibis top level as the CPU-visible control/status bank.
- Register contents are exported flat to downstream fabric.

---
 rtl/ibis_axil_regfile.sv | 172 +++++++++++++++++
 tb/tb_ibis_axil_regfile.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibis_axil_regfile.sv
// ibis_axil_regfile: parametrised AXI4-Lite slave register file.
// Address index = byte address >> log2(DATA_WIDTH/8). Out-of-range accesses
// return SLVERR. Register contents are exported flat on regs.
// Optional feature macro: IBIS_AXIL_WRITE_COUNT_EN adds a read-only counter
// of in-range committed writes at index NUM_REGS.
module ibis_axil_regfile #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           enable,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH:0] WR_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
`ifdef IBIS_AXIL_WRITE_COUNT_EN
    localparam logic [ADDR_WIDTH:0] RD_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS + 1);
`else
    localparam logic [ADDR_WIDTH:0] RD_LIMIT = WR_LIMIT;
`endif

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic [ADDR_WIDTH:0]   aw_idx;
    logic [ADDR_WIDTH:0]   ar_idx;
    logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic                  commit, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_val;

    // Readies are held low during reset so nothing is accepted on a reset edge
    assign awready = enable & ~areset & ~aw_held;
    assign wready  = enable & ~areset & ~w_held;
    assign arready = enable & ~areset & ~rvalid;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign ar_hs  = arvalid & arready;
    assign b_hs   = bvalid & bready;
    assign r_hs   = rvalid & rready;

    // Both halves held and no response pending: commit exactly once per write
    assign commit = aw_held & w_held & ~bvalid;

    assign aw_idx = {1'b0, aw_addr_q} >> OFFS;
    assign ar_idx = {1'b0, araddr} >> OFFS;
    assign wr_ok  = aw_idx < WR_LIMIT;
    assign rd_ok  = ar_idx < RD_LIMIT;

`ifdef IBIS_AXIL_WRITE_COUNT_EN
    logic [DATA_WIDTH-1:0] wr_count;

    // Count in-range committed writes, wrapping naturally
    always_ff @(posedge aclk) begin
        if (areset)
            wr_count <= '0;
        else if (commit && wr_ok)
            wr_count <= wr_count + 1'b1;
    end
`endif

    // Read mux over the register bank (and counter when present)
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == (ADDR_WIDTH+1)'(i))
                rd_val = mem[i];
        end
`ifdef IBIS_AXIL_WRITE_COUNT_EN
        if (ar_idx == WR_LIMIT)
            rd_val = wr_count;
`endif
    end

    // Register bank: reset fill and byte-strobed commit
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                mem[i] <= RESET_VALUE;
        end else if (commit && wr_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (aw_idx == (ADDR_WIDTH+1)'(i)) begin
                    for (int unsigned k = 0; k < STRB_W; k++) begin
                        if (wstrb_q[k])
                            mem[i][k*8 +: 8] <= wdata_q[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Write channel: independent AW/W capture, commit, B response
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? 2'b00 : 2'b10;
            end else if (b_hs) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Read channel: register the response on AR handshake, hold until R handshake
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= 2'b00;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_ok ? rd_val : '0;
            rresp  <= rd_ok ? 2'b00 : 2'b10;
        end else if (r_hs) begin
            rvalid <= 1'b0;
        end
    end

    // Flat export of the register bank
    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            regs[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end

endmodule

// File: tb/tb_ibis_axil_regfile.sv
// Scoreboard testbench for ibis_axil_regfile with a behavioural register model.
module tb_ibis_axil_regfile;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 16;
    localparam int SW = DW / 8;
    localparam logic [DW-1:0] RV = 32'h5A5A_00C3;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             enable = 1'b1;
    logic [AW-1:0]    awaddr = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [DW-1:0]    wdata = '0;
    logic [SW-1:0]    wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b0;
    logic [AW-1:0]    araddr = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [NR*DW-1:0] regs;

    ibis_axil_regfile #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .RESET_VALUE(RV)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .enable (enable),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .regs   (regs)
    );

    always #5 aclk = ~aclk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: plain array of register words
    logic [DW-1:0] model [NR];
`ifdef IBIS_AXIL_WRITE_COUNT_EN
    logic [DW-1:0] model_cnt = '0;
`endif

    logic [1:0]    exp_b [$];
    logic [DW+1:0] exp_r [$];   // {rresp, rdata}

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check_regs(string name);
        logic [NR*DW-1:0] e;
        for (int i = 0; i < NR; i++) e[i*DW +: DW] = model[i];
        n_tests++;
        if (regs !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, regs, e);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) model[i] = RV;
`ifdef IBIS_AXIL_WRITE_COUNT_EN
        model_cnt = '0;
`endif
    endfunction

    function automatic logic [1:0] model_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
        int unsigned idx = int'(a) / SW;
        if (idx >= NR) return 2'b10;
        for (int k = 0; k < SW; k++)
            if (s[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
`ifdef IBIS_AXIL_WRITE_COUNT_EN
        model_cnt = model_cnt + 1;
`endif
        return 2'b00;
    endfunction

    function automatic logic [DW+1:0] model_read(logic [AW-1:0] a);
        int unsigned idx = int'(a) / SW;
        if (idx < NR) return {2'b00, model[idx]};
`ifdef IBIS_AXIL_WRITE_COUNT_EN
        if (idx == NR) return {2'b00, model_cnt};
`endif
        return {2'b10, {DW{1'b0}}};
    endfunction

    // Monitor: pops expectations whenever a B or R handshake is about to occur
    always @(negedge aclk) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_b: got bresp %h, required no response", bresp);
            end else begin
                check("bresp", bresp, exp_b.pop_front());
                check_regs("regs_after_b");
            end
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_r: got rdata %h, required no response", rdata);
            end else begin
                logic [DW+1:0] e;
                e = exp_r.pop_front();
                check("rresp", rresp, e[DW+1:DW]);
                check("rdata", rdata, e[DW-1:0]);
            end
        end
    end

    // Waits for a handshake on channel ch; returns at active edge + 1
    task automatic wait_hs(input int ch, input string name);
        bit ok = 0;
        bit rdy;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge aclk);
            case (ch)
                0:       rdy = awready;
                1:       rdy = wready;
                2:       rdy = arready;
                3:       rdy = bvalid;
                default: rdy = rvalid;
            endcase
            @(posedge aclk);
            ok = rdy;
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL timeout_%s: got no handshake, required one within 64 cycles", name);
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input int awd, input int wd, input int bd);
        exp_b.push_back(model_write(a, d, s));
        fork
            begin
                idle(awd);
                awaddr = a; awvalid = 1'b1;
                wait_hs(0, "aw");
                awvalid = 1'b0; awaddr = AW'($urandom);
            end
            begin
                idle(wd);
                wdata = d; wstrb = s; wvalid = 1'b1;
                wait_hs(1, "w");
                wvalid = 1'b0; wdata = $urandom;
            end
        join
        check("bvalid_early", bvalid, 1'b0);
        idle(1);
        check("bvalid_latency", bvalid, 1'b1);
        idle(bd);
        bready = 1'b1;
        wait_hs(3, "b");
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ard, input int rd, input bit push);
        if (push) exp_r.push_back(model_read(a));
        idle(ard);
        araddr = a; arvalid = 1'b1;
        wait_hs(2, "ar");
        arvalid = 1'b0; araddr = AW'($urandom);
        check("rvalid_latency", rvalid, 1'b1);
        idle(rd);
        rready = 1'b1;
        wait_hs(4, "r");
        rready = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(64, 255));
        return AW'($urandom_range(0, 63));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset state
        idle(3);
        check("rst_awready", awready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, '0);
        check_regs("rst_regs");
        areset = 1'b0;
        idle(1);
        check("awready_idle", awready, 1'b1);

        // Directed cases
        do_read(8'h0C, 0, 0, 1);
        do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 2, 0);
        check("regs_idx2", regs[95:64], 32'hDEADBEEF);
        do_write(8'h14, 32'hAABBCCDD, 4'hF, 1, 0, 1);
        do_write(8'h14, 32'h11223344, 4'b0101, 0, 0, 0);
        check("strb_merge", regs[5*DW +: DW], 32'hAA22CC44);
        do_write(8'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        do_read(8'h40, 0, 1, 1);

        // bready held low for 5 cycles
        exp_b.push_back(model_write(8'h10, 32'h0BADF00D, 4'hF));
        awaddr = 8'h10; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_hs(0, "aw_hold");
        awvalid = 1'b0; wvalid = 1'b0;
        idle(1);
        for (int c = 0; c < 5; c++) begin
            check("hold_bvalid", bvalid, 1'b1);
            check("hold_bresp", bresp, 2'b00);
            check("hold_awready", awready, 1'b0);
            check("hold_wready", wready, 1'b0);
            idle(1);
        end
        bready = 1'b1;
        wait_hs(3, "b_hold");
        bready = 1'b0;
        check("awready_after_b", awready, 1'b1);

        // Commit and AR to the same index on one edge: old value returned
        exp_r.push_back(model_read(8'h08));
        fork
            do_write(8'h08, 32'h12345678, 4'hF, 0, 0, 0);
            begin
                idle(1);
                do_read(8'h08, 0, 0, 0);
            end
        join

        // enable low blocks new handshakes
        enable = 1'b0;
        arvalid = 1'b1; araddr = 8'h00;
        idle(1);
        check("en_awready", awready, 1'b0);
        check("en_wready", wready, 1'b0);
        check("en_arready", arready, 1'b0);
        idle(2);
        check("en_no_rvalid", rvalid, 1'b0);
        arvalid = 1'b0;
        enable = 1'b1;

        // Reset with AW held, W never sent
        awaddr = 8'h04; awvalid = 1'b1;
        wait_hs(0, "aw_rst");
        awvalid = 1'b0;
        areset = 1'b1;
        idle(1);
        areset = 1'b0;
        model_reset();
        check_regs("regs_after_rst");
        for (int c = 0; c < 4; c++) begin
            check("rst_no_bvalid", bvalid, 1'b0);
            idle(1);
        end

`ifdef IBIS_AXIL_WRITE_COUNT_EN
        do_write(8'h00, 32'h1, 4'hF, 0, 0, 0);
        do_write(8'h04, 32'h2, 4'hF, 0, 0, 0);
        do_write(8'h08, 32'h3, 4'hF, 0, 0, 0);
        do_write(8'hC0, 32'h4, 4'hF, 0, 0, 0);
        do_write(8'(NR * SW), 32'h5, 4'hF, 0, 0, 0);
        do_read(8'(NR * SW), 0, 0, 1);
`endif

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(rand_addr(), $urandom, SW'($urandom), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 2), $urandom_range(0, 3), 1);
        end

        idle(2);
        check_regs("regs_final");
        check("scoreboard_b_empty", exp_b.size(), 0);
        check("scoreboard_r_empty", exp_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
